// File: rtl/gpio_pin_ctrl.sv
// gpio_pin_ctrl: per-pin GPIO control between the pads and the GPIO register file.
//
// Input path: an input synchroniser, then a debounce filter, then detection of
// the configured edge, which pulses interrupt status towards the register file.
// Output path: drives the pad output value and enable from the register state.
// A toggle request is executed by writing back the inverted output value.
// irq_o is the registered OR of all pending, enabled interrupts.
//
// Ports:
//   clk_i          clock (single domain)
//   rst_i          asynchronous, active-high reset
//   gpio_in_i      raw pad inputs (asynchronous)
//   gpio_out_o     pad output values
//   gpio_out_en_o  pad output enables (1 = drive)
//   reg2hw_i       per-pin register state (dir, en, out, toggle, intrpt_en,
//                  intrpt, intrpt_edge)
//   hw2reg_o       per-pin updates (sync_in, out_valid, out, intrpt_valid, intrpt)
//   irq_o          aggregated interrupt, level

package gpio_pin_ctrl_pkg;

    typedef struct packed {
        logic dir;          // 1 = output
        logic en;           // pin enable
        logic out;          // output value
        logic toggle;       // invert request, one-cycle pulse
        logic intrpt_en;    // interrupt enable
        logic intrpt;       // interrupt status
        logic intrpt_edge;  // 0 = rising, 1 = falling
    } gpio_reg2hw_t;

    typedef struct packed {
        logic sync_in;
        logic out_valid;
        logic out;
        logic intrpt_valid;
        logic intrpt;
    } gpio_hw2reg_t;

endpackage

module gpio_pin_ctrl
    import gpio_pin_ctrl_pkg::*;
#(
    parameter int unsigned GpioCount      = 16,
    parameter int unsigned SyncStages     = 2,
    parameter int unsigned DebounceCycles = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic         [GpioCount-1:0]  gpio_in_i,
    output logic         [GpioCount-1:0]  gpio_out_o,
    output logic         [GpioCount-1:0]  gpio_out_en_o,
    input  gpio_reg2hw_t [GpioCount-1:0]  reg2hw_i,
    output gpio_hw2reg_t [GpioCount-1:0]  hw2reg_o,
    output logic                          irq_o
);

    localparam int unsigned     CntW   = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    logic [SyncStages-1:0] sync_q [GpioCount];
    logic [CntW-1:0]       cnt_q  [GpioCount];
    logic [GpioCount-1:0]  s;
    logic [GpioCount-1:0]  f_q;
    logic [GpioCount-1:0]  ev_q;
    logic [GpioCount-1:0]  irq_src;
    logic                  irq_q;

    always_comb begin
        s       = '0;
        irq_src = '0;
        for (int unsigned i = 0; i < GpioCount; i++) begin
            s[i]       = sync_q[i][SyncStages-1];
            irq_src[i] = reg2hw_i[i].intrpt & reg2hw_i[i].intrpt_en & reg2hw_i[i].en;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < GpioCount; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            f_q   <= '0;
            ev_q  <= '0;
            irq_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < GpioCount; i++) begin
                if (!reg2hw_i[i].en) begin
                    // Disabled pins hold all input state at 0 so that re-enabling
                    // restarts the chain and a high pad reads as a fresh rising edge.
                    sync_q[i] <= '0;
                    cnt_q[i]  <= '0;
                    f_q[i]    <= 1'b0;
                    ev_q[i]   <= 1'b0;
                end else begin
                    sync_q[i] <= {sync_q[i][SyncStages-2:0], gpio_in_i[i]};
                    ev_q[i]   <= 1'b0;
                    if (s[i] == f_q[i]) begin
                        cnt_q[i] <= '0;
                    end else if (cnt_q[i] == CntMax) begin
                        f_q[i]   <= s[i];
                        cnt_q[i] <= '0;
                        // New value 1 with edge 0 (rising) or 0 with edge 1 (falling).
                        ev_q[i]  <= reg2hw_i[i].intrpt_en & (s[i] ^ reg2hw_i[i].intrpt_edge);
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CntOne;
                    end
                end
            end
            irq_q <= |irq_src;
        end
    end

    always_comb begin
        gpio_out_o    = '0;
        gpio_out_en_o = '0;
        hw2reg_o      = '0;
        for (int unsigned i = 0; i < GpioCount; i++) begin
            gpio_out_o[i]            = reg2hw_i[i].out;
            gpio_out_en_o[i]         = reg2hw_i[i].en & reg2hw_i[i].dir;
            hw2reg_o[i].out_valid    = reg2hw_i[i].toggle & reg2hw_i[i].en;
            hw2reg_o[i].out          = ~reg2hw_i[i].out;
            hw2reg_o[i].sync_in      = f_q[i];
            hw2reg_o[i].intrpt_valid = ev_q[i];
            hw2reg_o[i].intrpt       = ev_q[i];
        end
    end

    assign irq_o = irq_q;

endmodule
